// File: rtl/gray_cmd_feeder.sv
// gray_cmd_feeder
//   Command-issue stage in front of the Gray-coded 16-state control FSM.
//   {cmd, hold} entries are buffered in a DEPTH-entry FIFO. Each entry is
//   driven on cmd for (hold+1) consecutive cycles. IDLE_CMD is driven
//   whenever no entry is active. Back-to-back entries issue with no bubble.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : write request
//   in_ready   : FIFO can accept ((level < DEPTH) && !flush)
//   in_cmd     : command to issue
//   in_hold    : extra hold cycles (0 = one cycle)
//   flush      : synchronous clear of FIFO and issue stage
//   cmd        : registered command to the FSM
//   cmd_valid  : registered, 1 while cmd carries a FIFO entry
//   level      : FIFO occupancy, not counting the entry being issued
//   issued_cnt : (GRAY_FEEDER_STATS_EN only) entries loaded into the issue
//                stage, wraps at 16 bits, cleared only by rst_n
//
// Build option: define GRAY_FEEDER_STATS_EN to add issued_cnt.
//
// state  | meaning
// S_IDLE | nothing on cmd, IDLE_CMD driven
// S_ISSUE| an entry is on cmd, r_cnt counts remaining extra cycles

module gray_cmd_feeder #(
  parameter int         DEPTH    = 4,
  parameter int         HOLD_W   = 4,
  parameter logic [3:0] IDLE_CMD = 4'b0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_cmd,
  input  logic [HOLD_W-1:0]        in_hold,
  input  logic                     flush,
  output logic [3:0]               cmd,
  output logic                     cmd_valid,
`ifdef GRAY_FEEDER_STATS_EN
  output logic [15:0]              issued_cnt,
`endif
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t            r_state;
  logic [HOLD_W-1:0] r_cnt;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic [3:0]        r_cmd;
  logic              r_cmd_valid;
  logic [3:0]        r_mem_cmd  [DEPTH];
  logic [HOLD_W-1:0] r_mem_hold [DEPTH];

  logic w_push;
  logic w_pop;

  assign in_ready = (r_level < LW'(DEPTH)) && !flush;
  assign w_push   = in_valid && in_ready;
  // A new entry is loaded whenever the issue stage is free or finishing its
  // last cycle; flush overrides it.
  assign w_pop    = (r_level != '0) && ((r_state == S_IDLE) || (r_cnt == '0)) && !flush;

  assign cmd       = r_cmd;
  assign cmd_valid = r_cmd_valid;
  assign level     = r_level;

  // Storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_cmd[r_wr_ptr]  <= in_cmd;
      r_mem_hold[r_wr_ptr] <= in_hold;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_cmd       <= IDLE_CMD;
      r_cmd_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_cmd       <= IDLE_CMD;
      r_cmd_valid <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (!w_push && w_pop) r_level <= r_level - LW'(1);

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_cmd       <= r_mem_cmd[r_rd_ptr];
            r_cnt       <= r_mem_hold[r_rd_ptr];
            r_cmd_valid <= 1'b1;
            r_state     <= S_ISSUE;
          end else begin
            r_cmd       <= IDLE_CMD;
            r_cmd_valid <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (w_pop) begin
            r_cmd       <= r_mem_cmd[r_rd_ptr];
            r_cnt       <= r_mem_hold[r_rd_ptr];
            r_cmd_valid <= 1'b1;
          end else begin
            r_cmd       <= IDLE_CMD;
            r_cmd_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd       <= IDLE_CMD;
          r_cmd_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef GRAY_FEEDER_STATS_EN
  logic [15:0] r_issued_cnt;

  // Flush intentionally leaves this count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_issued_cnt <= '0;
    else if (w_pop) r_issued_cnt <= r_issued_cnt + 16'd1;
  end

  assign issued_cnt = r_issued_cnt;
`endif

endmodule

// File: tb/tb_gray_cmd_feeder.sv
module tb_gray_cmd_feeder;

  localparam int DEPTH = 4;
  localparam int HOLD_W = 4;
  localparam logic [3:0] IDLE_CMD = 4'b0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [3:0] in_cmd = '0;
  logic [HOLD_W-1:0] in_hold = '0;
  logic flush = 1'b0;
  logic [3:0] cmd;
  logic cmd_valid;
  logic [2:0] level;
`ifdef GRAY_FEEDER_STATS_EN
  logic [15:0] issued_cnt;
`endif

  gray_cmd_feeder #(.DEPTH(DEPTH), .HOLD_W(HOLD_W), .IDLE_CMD(IDLE_CMD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_hold(in_hold), .flush(flush),
    .cmd(cmd), .cmd_valid(cmd_valid),
`ifdef GRAY_FEEDER_STATS_EN
    .issued_cnt(issued_cnt),
`endif
    .level(level)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: pending entries, current entry and cycles left on it.
  typedef struct {logic [3:0] c; int h;} entry_t;
  typedef struct {logic [3:0] c; logic v; int lvl; int iss;} exp_t;
  entry_t m_fifo[$];
  exp_t   exp_q[$];
  logic [3:0] m_cmd;
  logic m_busy;
  int m_left;         // cycles remaining on cmd for the current entry, incl. the present one
  int m_issued;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fifo.delete(); exp_q.delete();
      m_busy = 0; m_left = 0; m_cmd = IDLE_CMD; m_issued = 0;
    end else begin
      bit acc;
      entry_t e;
      exp_t x;
      if (flush) begin
        m_fifo.delete(); m_busy = 0; m_left = 0; m_cmd = IDLE_CMD;
      end else begin
        acc = in_valid && (m_fifo.size() < DEPTH);
        if (m_busy && m_left > 1) begin
          m_left--;
        end else if (m_fifo.size() > 0) begin
          e = m_fifo.pop_front();
          m_cmd = e.c; m_left = e.h + 1; m_busy = 1;
          m_issued = (m_issued + 1) % 65536;
        end else begin
          m_busy = 0; m_left = 0; m_cmd = IDLE_CMD;
        end
        if (acc) begin
          e.c = in_cmd; e.h = int'(in_hold);
          m_fifo.push_back(e);
        end
      end
      x.c = m_cmd; x.v = m_busy; x.lvl = m_fifo.size(); x.iss = m_issued;
      exp_q.push_back(x);
    end
  end

  // Monitor: compares the DUT output after each edge with the model's entry.
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      check("cmd_valid", int'(cmd_valid), int'(x.v));
      check("cmd", int'(cmd), int'(x.c));
      check("level", int'(level), x.lvl);
      check("in_ready", int'(in_ready), int'((x.lvl < DEPTH) && !flush));
`ifdef GRAY_FEEDER_STATS_EN
      check("issued_cnt", int'(issued_cnt), x.iss);
`endif
    end
  end

  task automatic step(input logic v, input logic [3:0] c, input int h, input logic f);
    @(negedge clk); #1;
    in_valid = v; in_cmd = c; in_hold = HOLD_W'(h); flush = f;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    #12;
    check("rst_cmd", int'(cmd), int'(IDLE_CMD));
    check("rst_valid", int'(cmd_valid), 0);
    check("rst_level", int'(level), 0);
    @(negedge clk); #1; rst_n = 1'b1;
    idle(10);

    // single entry, hold 0
    step(1'b1, 4'b0011, 0, 1'b0);
    idle(4);
    // back-to-back hold 2 then hold 0
    step(1'b1, 4'b0101, 2, 1'b0);
    step(1'b1, 4'b1000, 0, 1'b0);
    idle(6);
    // long hold fills the FIFO; extra pushes are held off
    step(1'b1, 4'b0001, 15, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 4'(i + 2), 1, 1'b0);
    step(1'b1, 4'b1111, 0, 1'b0);
    idle(40);
    // flush during first entry's hold with a concurrent push
    step(1'b1, 4'b1010, 5, 1'b0);
    step(1'b1, 4'b1011, 5, 1'b0);
    step(1'b1, 4'b1100, 5, 1'b0);
    idle(2);
    step(1'b1, 4'b1101, 3, 1'b1);
    idle(8);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 99) < 60), 4'($urandom), ($urandom_range(0, 9) < 7) ? $urandom_range(0, 2) : $urandom_range(0, 15),
           1'($urandom_range(0, 49) == 0));
    end
    idle(70);

    // stats: 5 entries, flush, 2 entries -> 7 loads since last reset
    @(negedge clk); #1; rst_n = 1'b0;
    #2; rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 4'(i + 1), 0, 1'b0);
    idle(10);
    step(1'b0, 4'h0, 0, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b1, 4'(i + 9), 0, 1'b0);
    idle(6);
`ifdef GRAY_FEEDER_STATS_EN
    check("issued_total", int'(issued_cnt), 7);
`endif

    // async reset mid-hold
    step(1'b1, 4'b0110, 10, 1'b0);
    idle(4);
    check("midhold_valid", int'(cmd_valid), 1);
    #1; rst_n = 1'b0;
    #1;
    check("arst_cmd", int'(cmd), int'(IDLE_CMD));
    check("arst_valid", int'(cmd_valid), 0);
    check("arst_level", int'(level), 0);
`ifdef GRAY_FEEDER_STATS_EN
    check("arst_issued", int'(issued_cnt), 0);
`endif
    @(negedge clk); #1; rst_n = 1'b1;
    idle(15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gray_cmd_feeder.md
Name: gray_cmd_feeder

Overview:
Upstream command-issue stage for the Gray-coded 16-state control FSM.
- Buffers {cmd, hold} entries in a small FIFO.
- Drives the FSM's 4-bit cmd input, holding each command for (hold+1) consecutive cycles.
- Drives IDLE_CMD whenever no command is active.
- Sits between the host/sequencer write interface and the FSM's cmd port.

Parameters:
DEPTH, 4, FIFO entries; power of 2, >= 2
HOLD_W, 4, width of per-entry hold count
IDLE_CMD, 4'b0000, value driven on cmd while idle or flushed

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  write request
in_ready  output  1  FIFO can accept; equals (level < DEPTH) && !flush
in_cmd  input  4  command to issue
in_hold  input  HOLD_W  extra cycles to hold in_cmd (0 = one cycle)
flush  input  1  synchronous clear of FIFO and issue stage
cmd  output  4  registered command to FSM
cmd_valid  output  1  registered, 1 while cmd carries a FIFO entry
level  output  $clog2(DEPTH)+1  FIFO occupancy, excluding the entry in the issue stage

Behaviour:
- Reset (async, rst_n=0): cmd=IDLE_CMD, cmd_valid=0, level=0, FIFO pointers=0, hold counter=0, state=IDLE.
- Push: accepted on a rising edge when in_valid && in_ready; written at the tail.
  - in_ready is combinational from registered level and flush.
  - Full: in_ready=0 even if a pop occurs the same cycle; no simultaneous push-on-full.
- Issue FSM, two states:
  - IDLE, level>0: pop head at the edge; cmd<=head.cmd, cnt<=head.hold, cmd_valid<=1, go ISSUE.
  - IDLE, level==0: cmd=IDLE_CMD, cmd_valid=0.
  - ISSUE, cnt>0: cnt<=cnt-1; cmd unchanged.
  - ISSUE, cnt==0, level>0: pop and load the next entry on the same edge. Back-to-back, no bubble.
  - ISSUE, cnt==0, level==0: go IDLE; cmd<=IDLE_CMD, cmd_valid<=0.
- Latency: entry pushed at edge N into an empty FIFO with the issue stage IDLE appears on cmd after edge N+1. There is no bypass path.
- An entry with hold=h occupies cmd for exactly h+1 cycles.
- Simultaneous push and pop on the same edge: level unchanged; pointers both advance.
- Pointers wrap modulo DEPTH; level ranges 0..DEPTH.
- Flush (synchronous, highest priority after reset), at the next edge:
  - level=0, pointers=0, state=IDLE, cmd=IDLE_CMD, cmd_valid=0.
  - A concurrent push is dropped; in_ready=0 during the flush cycle.
- Async reset mid-issue: outputs return to reset values immediately; no partial hold resumes after release.
- cmd is driven only from a register, never combinationally from the FIFO.

Optional Feature:
GRAY_FEEDER_STATS_EN
- Defined: adds output issued_cnt[15:0]. It increments by 1 on every edge that loads an entry into the issue stage and wraps at 16'hFFFF->0. It is cleared by rst_n only; flush does not clear it.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, no pushes -> cmd=4'b0000, cmd_valid=0, level=0, in_ready=1 for 10 cycles.
- Push {cmd=4'b0011, hold=0} at edge N -> cmd=4'b0011, cmd_valid=1 for exactly one cycle after edge N+1, then IDLE_CMD, cmd_valid=0.
- Push {4'b0101,hold=2} then {4'b1000,hold=0} on consecutive edges -> cmd=0101 for 3 cycles, then 1000 for 1 cycle with no idle gap, then IDLE.
- Push {4'b0001,hold=15}, then 5 more entries on back-to-back edges -> level reaches 4 and in_ready=0. The 6th push is held off until the first pop.
- Load 3 entries, assert flush during the first entry's hold -> next edge cmd=IDLE_CMD, cmd_valid=0, level=0, in_ready=1. Nothing issues afterward.
- With GRAY_FEEDER_STATS_EN: issue 5 entries, then flush, then issue 2 -> issued_cnt=7. Assert rst_n=0 mid-hold -> issued_cnt=0 and cmd=IDLE_CMD immediately.
